// File: rtl/restador_pkg.sv
// restador_pkg: shared width default and golden subtract reference used by
// the restador_reg assertions and its bench.
package restador_pkg;
    localparam int RESTADOR_WIDTH_DEF = 5;
    function automatic logic [RESTADOR_WIDTH_DEF:0] sub_ref(
        input logic [RESTADOR_WIDTH_DEF-1:0] a,
        input logic [RESTADOR_WIDTH_DEF-1:0] b
    );
        logic [RESTADOR_WIDTH_DEF:0] t;
        t = {1'b0, a} - {1'b0, b};
        return {~t[RESTADOR_WIDTH_DEF], t[RESTADOR_WIDTH_DEF-1:0]};
    endfunction
endpackage

// File: rtl/restador_bit.sv
// restador_bit: one-bit full subtractor cell of the ripple-borrow chain.
module restador_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

// File: rtl/restador_reg.sv
// restador_reg: registered ripple-borrow subtractor with a no-borrow flag.
// Defining RESTADOR_OVF_EN adds the registered signed-overflow output ovf.
module restador_reg
    import restador_pkg::*;
#(
    parameter int WIDTH = RESTADOR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] minuendo,
    input  logic [WIDTH-1:0] sustraendo,
    output logic             out_valid,
    output logic [WIDTH-1:0] restador,
    output logic             C_out
`ifdef RESTADOR_OVF_EN
    ,
    output logic             ovf
`endif
);
    logic [WIDTH:0]   w_bor;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] r_diff;
    logic             r_c;
    logic             r_valid;

    assign w_bor[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            restador_bit u_bit (
                .i_a    (minuendo[i]),
                .i_b    (sustraendo[i]),
                .i_bin  (w_bor[i]),
                .o_d    (w_diff[i]),
                .o_bout (w_bor[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_diff  <= '0;
            r_c     <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_diff <= w_diff;
                r_c    <= ~w_bor[WIDTH];
            end
        end
    end

    assign out_valid = r_valid;
    assign restador  = r_diff;
    assign C_out     = r_c;

`ifdef RESTADOR_OVF_EN
    logic r_ovf;
    always_ff @(posedge clk) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (in_valid)
            r_ovf <= (minuendo[WIDTH-1] != sustraendo[WIDTH-1]) && (w_diff[WIDTH-1] != minuendo[WIDTH-1]);
    end
    assign ovf = r_ovf;
`endif

    generate
        if (WIDTH == RESTADOR_WIDTH_DEF) begin : g_chk
            // the chain must agree with the reference on every captured operation
            a_ref: assert property (@(posedge clk) disable iff (rst)
                in_valid |=> {C_out, restador} == sub_ref($past(minuendo), $past(sustraendo)));
        end
    endgenerate
endmodule

// File: tb/tb_restador_reg.sv
// tb_restador_reg: scoreboard bench for restador_reg; exercises the ovf port
// when RESTADOR_OVF_EN is defined.
module tb_restador_reg;
    localparam int W = 5;

    typedef struct packed {
        logic [W-1:0] d;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] minuendo;
    logic [W-1:0] sustraendo;
    logic         out_valid;
    logic [W-1:0] restador;
    logic         C_out;
`ifdef RESTADOR_OVF_EN
    logic         ovf;
`endif

    exp_t q[$];
    exp_t last;
    exp_t e;
    int   n_chk = 0;
    int   n_err = 0;

    restador_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .minuendo   (minuendo),
        .sustraendo (sustraendo),
        .out_valid  (out_valid),
        .restador   (restador),
        .C_out      (C_out)
`ifdef RESTADOR_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t m;
        m.d = W'((a - b) & ((1 << W) - 1));
        m.c = (a >= b);
        m.o = (a[W-1] != b[W-1]) && (m.d[W-1] != a[W-1]);
        return m;
    endfunction

    task automatic step(input logic v, input logic r, input int a, input int b);
        rst        = r;
        in_valid   = v;
        minuendo   = W'(a);
        sustraendo = W'(b);
        if (v && !r) q.push_back(model(a, b));
        @(posedge clk);
        #1;
        chk("valid", {31'd0, out_valid}, {31'd0, v && !r});
        if (r) begin
            last = '0;
            chk("rst_diff", {27'd0, restador}, 32'd0);
            chk("rst_c", {31'd0, C_out}, 32'd0);
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("q_empty", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("diff", {27'd0, restador}, {27'd0, e.d});
                chk("c_out", {31'd0, C_out}, {31'd0, e.c});
`ifdef RESTADOR_OVF_EN
                chk("ovf", {31'd0, ovf}, {31'd0, e.o});
`endif
                last = e;
            end
        end else begin
            chk("hold_diff", {27'd0, restador}, {27'd0, last.d});
            chk("hold_c", {31'd0, C_out}, {31'd0, last.c});
        end
    endtask

    initial begin
        last = '0;
        step(1'b1, 1'b1, 9, 2);
        step(1'b1, 1'b1, 9, 2);
        step(1'b1, 1'b0, 7, 3);
        chk("t2_diff", {27'd0, restador}, 32'd4);
        chk("t2_c", {31'd0, C_out}, 32'd1);
        step(1'b1, 1'b0, 3, 7);
        chk("t3_diff", {27'd0, restador}, 32'd28);
        chk("t3_c", {31'd0, C_out}, 32'd0);
        step(1'b1, 1'b0, 15, 15);
        chk("eq_diff", {27'd0, restador}, 32'd0);
        chk("eq_c", {31'd0, C_out}, 32'd1);
        step(1'b1, 1'b0, 0, 31);
        chk("min_max_diff", {27'd0, restador}, 32'd1);
        chk("min_max_c", {31'd0, C_out}, 32'd0);
        step(1'b1, 1'b0, 22, 0);
        chk("b0_diff", {27'd0, restador}, 32'd22);
        chk("b0_c", {31'd0, C_out}, 32'd1);
        for (int a = 1; a <= 15; a++)
            for (int b = 0; b <= 14; b++)
                step(1'b1, 1'b0, a, b);
        step(1'b1, 1'b0, 12, 5);
        step(1'b0, 1'b0, 30, 1);
        chk("t5_hold", {27'd0, restador}, 32'd7);
        step(1'b0, 1'b0, 2, 9);
        step(1'b1, 1'b0, 20, 3);
        step(1'b1, 1'b1, 4, 1);
        step(1'b1, 1'b0, 25, 31);
`ifdef RESTADOR_OVF_EN
        step(1'b1, 1'b0, 16, 1);
        chk("t6_diff", {27'd0, restador}, 32'd15);
        chk("t6_ovf1", {31'd0, ovf}, 32'd1);
        step(1'b1, 1'b0, 5, 1);
        chk("t6_ovf0", {31'd0, ovf}, 32'd0);
`endif
        step(1'b0, 1'b0, 0, 0);
        chk("q_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
